// File: rtl/microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_timer_ctrl
//   Cooking-timer controller. Collects keypad digits into a 4-digit BCD mm:ss
//   setpoint, counts it down once per 1 Hz tick while cooking, enforces the
//   door interlock and sequences the end-of-cook beep.
//
// Ports
//   Clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   tick         in   one-cycle 1 Hz enable
//   key_valid    in   one-cycle strobe qualifying key_digit
//   key_digit    in   BCD keypad digit (values above 9 ignored)
//   start        in   one-cycle start/resume strobe
//   stop_clear   in   one-cycle stop/clear strobe
//   door_open    in   door level, 1 = open
//   min_tens..sec_ones out  remaining/set time, BCD
//   magnetron_on out  registered power enable, high only while cooking
//   lamp_on      out  door_open OR cooking (combinational)
//   beep         out  registered, high in DONE until the beep count expires
//   state        out  IDLE=0, COOK=1, PAUSE=2, DONE=3
// -----------------------------------------------------------------------------
module microwave_timer_ctrl #(
  parameter int unsigned BEEP_TICKS     = 3,
  parameter int unsigned QUICK_SEC_TENS = 3
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       magnetron_on,
  output logic       lamp_on,
  output logic       beep,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BEEP_LOAD  = 4'(BEEP_TICKS);
  localparam logic [3:0] QUICK_TENS = 4'(QUICK_SEC_TENS);

  state_t     state_q;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] beep_cnt_q;
  logic       mag_q;
  logic       beep_q;

  logic [3:0] dec_mt_d, dec_mo_d, dec_st_d, dec_so_d;
  logic       dec_zero_s;
  logic       time_zero_s;

  // One-second BCD decrement of the current time; holds at 00:00 so it never wraps.
  // Seconds digits are taken literally, so 01:75 runs down to 01:00 before borrowing.
  always_comb begin
    dec_mt_d = mt_q;
    dec_mo_d = mo_q;
    dec_st_d = st_q;
    dec_so_d = so_q;
    if (so_q != 4'd0) begin
      dec_so_d = so_q - 4'd1;
    end else if (st_q != 4'd0) begin
      dec_st_d = st_q - 4'd1;
      dec_so_d = 4'd9;
    end else if (mo_q != 4'd0) begin
      dec_mo_d = mo_q - 4'd1;
      dec_st_d = 4'd5;
      dec_so_d = 4'd9;
    end else if (mt_q != 4'd0) begin
      dec_mt_d = mt_q - 4'd1;
      dec_mo_d = 4'd9;
      dec_st_d = 4'd5;
      dec_so_d = 4'd9;
    end else begin
      dec_so_d = so_q;
    end
  end

  assign dec_zero_s  = (dec_mt_d == 4'd0) && (dec_mo_d == 4'd0) &&
                       (dec_st_d == 4'd0) && (dec_so_d == 4'd0);
  assign time_zero_s = (mt_q == 4'd0) && (mo_q == 4'd0) &&
                       (st_q == 4'd0) && (so_q == 4'd0);

  // Controller FSM with digit register, beep counter and registered outputs.
  // Within a cycle only the highest-priority asserted event is acted on:
  // door_open > stop_clear > start > key_valid > tick.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mt_q       <= 4'd0;
      mo_q       <= 4'd0;
      st_q       <= 4'd0;
      so_q       <= 4'd0;
      beep_cnt_q <= 4'd0;
      mag_q      <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (door_open) begin
            state_q <= ST_IDLE;
          end else if (stop_clear) begin
            mt_q <= 4'd0;
            mo_q <= 4'd0;
            st_q <= 4'd0;
            so_q <= 4'd0;
          end else if (start) begin
            if (time_zero_s) begin
              st_q <= QUICK_TENS;
            end
            state_q <= ST_COOK;
            mag_q   <= 1'b1;
          end else if (key_valid) begin
            if (key_digit <= 4'd9) begin
              mt_q <= mo_q;
              mo_q <= st_q;
              st_q <= so_q;
              so_q <= key_digit;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_COOK: begin
          if (door_open || stop_clear) begin
            state_q <= ST_PAUSE;
            mag_q   <= 1'b0;
          end else if (start || key_valid) begin
            // Higher-priority strobe swallows any coincident tick.
            state_q <= ST_COOK;
          end else if (tick) begin
            mt_q <= dec_mt_d;
            mo_q <= dec_mo_d;
            st_q <= dec_st_d;
            so_q <= dec_so_d;
            if (dec_zero_s) begin
              state_q    <= ST_DONE;
              mag_q      <= 1'b0;
              beep_q     <= 1'b1;
              beep_cnt_q <= BEEP_LOAD;
            end
          end else begin
            state_q <= ST_COOK;
          end
        end

        ST_PAUSE: begin
          if (door_open) begin
            state_q <= ST_PAUSE;
          end else if (stop_clear) begin
            state_q <= ST_IDLE;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
          end else if (start) begin
            state_q <= ST_COOK;
            mag_q   <= 1'b1;
          end else begin
            state_q <= ST_PAUSE;
          end
        end

        ST_DONE: begin
          if (door_open || stop_clear) begin
            state_q    <= ST_IDLE;
            beep_q     <= 1'b0;
            beep_cnt_q <= 4'd0;
          end else if (start || key_valid) begin
            state_q <= ST_DONE;
          end else if (tick) begin
            if (beep_cnt_q <= 4'd1) begin
              state_q    <= ST_IDLE;
              beep_q     <= 1'b0;
              beep_cnt_q <= 4'd0;
            end else begin
              beep_cnt_q <= beep_cnt_q - 4'd1;
            end
          end else begin
            state_q <= ST_DONE;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          mag_q      <= 1'b0;
          beep_q     <= 1'b0;
          beep_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  assign min_tens     = mt_q;
  assign min_ones     = mo_q;
  assign sec_tens     = st_q;
  assign sec_ones     = so_q;
  assign magnetron_on = mag_q;
  assign beep         = beep_q;
  assign state        = state_q;
  assign lamp_on      = door_open | (state_q == ST_COOK);

endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Cooking-timer controller for the microwave: accepts keypad digits into a 4-digit BCD mm:ss setpoint, counts it down once per second while cooking, and enforces the door interlock. It sequences the cook-time countdown that drives the display counters and the magnetron enable. It sits between keypad/door inputs and the display/power outputs. All logic runs on `Clk` and uses a 1 Hz enable from the existing prescaler.

## Interface
- `BEEP_TICKS`, default 3: number of `tick` pulses for which `beep` stays high in DONE. Range 1–15.
- `QUICK_SEC_TENS`, default 3: seconds-tens digit loaded on a quick start. With the default, quick start loads 00:30.
- `Clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset. `reset` = 0 forces reset state immediately.
- `tick`  in  1  one-cycle 1 Hz enable pulse.
- `key_valid`  in  1  one-cycle strobe; `key_digit` is valid.
- `key_digit`  in  4  keypad digit in BCD. Values above 9 are ignored.
- `start`  in  1  one-cycle start/resume strobe.
- `stop_clear`  in  1  one-cycle stop/clear strobe.
- `door_open`  in  1  level; 1 = door open.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  remaining/set time in BCD.
- `magnetron_on`  out  1  power enable. Registered; 1 only in COOK.
- `lamp_on`  out  1  combinational: `door_open` OR (state == COOK).
- `beep`  out  1  registered; high in DONE until the beep count expires.
- `state`  out  2  encoding: IDLE = 0, COOK = 1, PAUSE = 2, DONE = 3.

## Operation
- Reset values: all digits 0, state IDLE, `magnetron_on` = 0, `beep` = 0, beep counter 0.
- Event priority within one cycle, highest first: `door_open` > `stop_clear` > `start` > `key_valid` > `tick`. Lower-priority events in the same cycle are dropped.
- **IDLE**
  - `key_valid` with `key_digit` ≤ 9 shifts the digits left: `min_tens` ← `min_ones` ← `sec_tens` ← `sec_ones` ← `key_digit`. The old `min_tens` is discarded.
  - `stop_clear` clears all digits to 0.
  - `start` with `door_open` = 0:
    - time ≠ 00:00 → COOK.
    - time = 00:00 → load 00:(`QUICK_SEC_TENS`)0, then COOK.
  - `start` with `door_open` = 1 is ignored.
  - `tick` has no effect.
- **COOK**
  - On each `tick`, decrement the BCD time:
    - `sec_ones` > 0 → `sec_ones` − 1.
    - else if `sec_tens` > 0 → `sec_tens` − 1, `sec_ones` = 9.
    - else if `min_ones` > 0 → `min_ones` − 1, `sec_tens` = 5, `sec_ones` = 9.
    - else `min_tens` − 1, `min_ones` = 9, `sec_tens` = 5, `sec_ones` = 9.
  - Entered seconds above 59 (e.g. 01:75) count down literally to x:00 before borrowing. No normalisation is applied.
  - A `tick` that yields 00:00 moves to DONE on the same edge and loads the beep counter with `BEEP_TICKS`.
  - `door_open` or `stop_clear` → PAUSE. Time is held.
  - Keys are ignored.
- **PAUSE**
  - `start` with `door_open` = 0 → COOK.
  - `stop_clear` → IDLE, digits cleared to 0.
  - Keys and `tick` are ignored.
- **DONE**
  - `beep` = 1. Each `tick` decrements the beep counter; reaching 0 → IDLE with `beep` = 0.
  - `stop_clear` or `door_open` → IDLE immediately, `beep` = 0.
  - Digits stay at 00:00.
- Countdown never wraps below 00:00. DONE is the only exit when time reaches 0.
- A `tick` never decrements in any state other than COOK.

## Timing
- All state and digit updates take effect on the rising `Clk` edge after the qualifying input cycle.
- `magnetron_on` rises one cycle after `start` is sampled.
- `magnetron_on` falls one cycle after `door_open` is sampled. Required latency ≤ 1 clock.
- `lamp_on` follows `door_open` with zero latency.
- `start` and `tick` in the same cycle: the transition to COOK happens and the `tick` is dropped. The first decrement occurs on the next `tick`.
- `tick` in the first COOK cycle decrements normally.
- Asserting `reset` mid-COOK drops `magnetron_on` asynchronously, clears the time, and returns to IDLE. Release is synchronous to the next edge.
- Key entry: one shift per `key_valid` pulse. A digit appears on the outputs one cycle after its strobe.

## Test plan
- Keys 1, 2, 3, 4, then start → display 12:34, `magnetron_on` = 1. After 35 ticks → 11:59. A further 719 ticks → 00:00, DONE, `beep` = 1 for exactly 3 ticks, then IDLE.
- Start on 00:00 with door closed → 00:30, COOK. Start with `door_open` = 1 → stays IDLE, `lamp_on` = 1.
- COOK at 05:00, raise `door_open` → PAUSE next edge, `magnetron_on` = 0, time 05:00 held through 10 ticks. Close the door, start → resumes COOK and counts 04:59 on the next tick.
- Enter 01:75 → counts 01:75…01:00, then 00:59…00:00. Five keys 9, 8, 7, 6, 5 → 87:65.
- PAUSE + `stop_clear` → IDLE, 00:00. `key_digit` = 12 in IDLE → no change. `start` + `stop_clear` in the same cycle in COOK → PAUSE.
- `reset` low mid-COOK at 03:21 → all outputs 0 immediately, state IDLE. After release, a `tick` → no change.
